// File: rtl/inst_encoder.sv
// RV32I field-level instruction encoder with LI (LUI+ADDI) expansion and a valid/ready output register.
// Optional immediate range checking is enabled by defining INST_ENCODER_IMM_CHECK_EN.
module inst_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [4:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_func3,
  input  logic [6:0]        in_func7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_LI   = 3'd6,
    FMT_RSVD = 3'd7
  } fmt_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LI2  = 1'b1
  } state_e;

  localparam logic [4:0] OP_OP_IMM = 5'b00100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [1:0] INST_LSB  = 2'b11;

  state_e              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [31:0]         out_inst_q, out_inst_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic                err_q, err_d;
  logic [31:0]         pend_inst_q, pend_inst_d;

  logic                accept;
  logic                out_hs;
  fmt_e                fmt;

  logic [31:0]         enc_word;
  logic [31:0]         enc_pend;
  logic                enc_emit;
  logic                enc_pend_en;
  logic                enc_drop;
  logic                imm_is_12b;
  logic [19:0]         li_hi;

  function automatic logic [31:0] addi_word(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, OP_OP_IMM, INST_LSB};
  endfunction

  function automatic logic [31:0] lui_word(input logic [4:0] rd, input logic [19:0] hi);
    return {hi, rd, OP_LUI, INST_LSB};
  endfunction

  assign fmt      = fmt_e'(in_fmt);
  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;

  // Rounding the upper part by imm[11] compensates for ADDI sign-extending the low 12 bits.
  assign imm_is_12b = (in_imm[31:11] == {21{in_imm[11]}});
  assign li_hi      = in_imm[31:12] + {19'd0, in_imm[11]};

`ifdef INST_ENCODER_IMM_CHECK_EN
  logic imm_ok;

  always_comb begin
    imm_ok = 1'b1;
    case (fmt)
      FMT_I, FMT_S: imm_ok = imm_is_12b;
      FMT_B:        imm_ok = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
      FMT_J:        imm_ok = (in_imm[31:20] == {12{in_imm[20]}}) && !in_imm[0];
      FMT_U:        imm_ok = (in_imm[11:0] == 12'd0);
      default:      imm_ok = 1'b1;
    endcase
  end
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    enc_word    = '0;
    enc_pend    = '0;
    enc_emit    = 1'b1;
    enc_pend_en = 1'b0;
    enc_drop    = 1'b0;
    case (fmt)
      FMT_R:  enc_word = {in_func7, in_rs2, in_rs1, in_func3, in_rd, in_opcode, INST_LSB};
      FMT_I:  enc_word = {in_imm[11:0], in_rs1, in_func3, in_rd, in_opcode, INST_LSB};
      FMT_S:  enc_word = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0],
                          in_opcode, INST_LSB};
      FMT_B:  enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                          in_imm[4:1], in_imm[11], in_opcode, INST_LSB};
      FMT_U:  enc_word = {in_imm[31:12], in_rd, in_opcode, INST_LSB};
      FMT_J:  enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                          in_rd, in_opcode, INST_LSB};
      FMT_LI: begin
        if (imm_is_12b) begin
          enc_word = addi_word(in_rd, 5'd0, in_imm[11:0]);
        end else begin
          enc_word    = lui_word(in_rd, li_hi);
          enc_pend    = addi_word(in_rd, in_rd, in_imm[11:0]);
          enc_pend_en = (in_imm[11:0] != 12'd0);
        end
      end
      default: begin
        enc_emit = 1'b0;
        enc_drop = 1'b1;
      end
    endcase
`ifdef INST_ENCODER_IMM_CHECK_EN
    if (!imm_ok) begin
      enc_emit    = 1'b0;
      enc_pend_en = 1'b0;
      enc_drop    = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_addr_d  = out_addr_q;
    pend_inst_d = pend_inst_q;
    err_d       = 1'b0;

    if (out_hs) begin
      out_valid_d = 1'b0;
      out_addr_d  = out_addr_q + ADDR_W'(1);
    end

    // The held ADDI follows the LUI directly; the LI2 state blocks new requests meanwhile.
    if (state_q == ST_LI2 && out_hs) begin
      out_inst_d  = pend_inst_q;
      out_valid_d = 1'b1;
      state_d     = ST_IDLE;
    end

    if (accept) begin
      err_d = enc_drop;
      if (enc_emit) begin
        out_valid_d = 1'b1;
        out_inst_d  = enc_word;
      end
      if (enc_pend_en) begin
        state_d     = ST_LI2;
        pend_inst_d = enc_pend;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_addr_q  <= ADDR_W'(BASE_ADDR);
      err_q       <= 1'b0;
      pend_inst_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_addr_q  <= out_addr_d;
      err_q       <= err_d;
      pend_inst_q <= pend_inst_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_addr  = out_addr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder (ADDR_W=2 so address wrap is visible); expectations are hand-encoded words.
module tb_inst_encoder;

  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [4:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_func3;
  logic [6:0]        in_func7;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_func3  (in_func3),
    .in_func7  (in_func7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_addr  (out_addr),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] fmt, input logic [4:0] op, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [31:0] imm);
    in_valid  = 1'b1;
    in_fmt    = fmt;
    in_opcode = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_func3  = f3;
    in_func7  = f7;
    in_imm    = imm;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [31:0] inst, input int addr);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_inst"}, out_inst, inst);
    check({tag, "_addr"}, {30'd0, out_addr}, 32'(addr));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    req(3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    idle();
    tick();
    tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_inst", out_inst, 32'd0);
    check("rst_addr", {30'd0, out_addr}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);

    // add x3,x1,x2
    rst_n = 1'b1;
    req(3'd0, 5'b01100, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    check("r_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check_out("r", 32'h002081B3, 0);

    // beq x1,x2,+8 accepted while the R word is handshaken
    req(3'd3, 5'b11000, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    tick();
    check_out("b8", 32'h00208463, 1);

    // LI x5,0x12345FFF -> LUI + ADDI; opcode field must be ignored
    req(3'd6, 5'b11111, 5'd5, 5'd9, 5'd9, 3'd7, 7'd0, 32'h12345FFF);
    tick();
    idle();
    check_out("li_lui", 32'h123462B7, 2);
    check("li2_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check_out("li_addi", 32'hFFF28293, 3);
    check("li_done_ready", {31'd0, in_ready}, 32'd1);

    // LI x5,5 -> single ADDI, address wraps to 0
    req(3'd6, 5'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    check_out("li_small", 32'h00500293, 0);

    // beq x0,x0,-4
    req(3'd3, 5'b11000, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC);
    tick();
    check_out("b_neg", 32'hFE000EE3, 1);

    // LI with zero low part -> LUI only, no LI2 state
    req(3'd6, 5'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    tick();
    check_out("li_lui_only", 32'h123452B7, 2);
    check("li_lui_only_rdy", {31'd0, in_ready}, 32'd1);

    // LI x5,2048: just outside the ADDI range
    req(3'd6, 5'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    tick();
    idle();
    check_out("li2048_lui", 32'h000012B7, 3);
    check("li2048_rdy", {31'd0, in_ready}, 32'd0);
    tick();
    check_out("li2048_addi", 32'h80028293, 0);
    tick();
    check("drain_valid", {31'd0, out_valid}, 32'd0);
    check("drain_addr", {30'd0, out_addr}, 32'd1);

    // Backpressure: addi x1,x0,1 held while sw x2,4(x1) waits
    out_ready = 1'b0;
    req(3'd1, 5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    tick();
    check_out("bp_first", 32'h00100093, 1);
    req(3'd2, 5'b01000, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd4);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("bp_hold", 32'h00100093, 1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check_out("bp_sw", 32'h0020A223, 2);
    // jal x1,+2048
    req(3'd5, 5'b11011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800);
    tick();
    check_out("bp_jal", 32'h001000EF, 3);
    // lui x7,0xABCDE
    req(3'd4, 5'b01101, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000);
    tick();
    check_out("bp_lui", 32'hABCDE3B7, 0);
    idle();
    tick();
    check("bp_end_valid", {31'd0, out_valid}, 32'd0);
    check("bp_end_addr", {30'd0, out_addr}, 32'd1);

    // Reserved format: accepted, dropped, err pulses once
    req(3'd7, 5'b01100, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    check("rsvd_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    idle();
    check("rsvd_err", {31'd0, err}, 32'd1);
    check("rsvd_valid", {31'd0, out_valid}, 32'd0);
    check("rsvd_addr", {30'd0, out_addr}, 32'd1);
    tick();
    check("rsvd_err_clr", {31'd0, err}, 32'd0);

    // I-format with out-of-range immediate 2048
    req(3'd1, 5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    tick();
    idle();
`ifdef INST_ENCODER_IMM_CHECK_EN
    check("imm_chk_err", {31'd0, err}, 32'd1);
    check("imm_chk_valid", {31'd0, out_valid}, 32'd0);
    check("imm_chk_addr", {30'd0, out_addr}, 32'd1);
`else
    check("imm_trunc_err", {31'd0, err}, 32'd0);
    check_out("imm_trunc", 32'h80000093, 1);
`endif
    tick();

    // Reset between the LI words discards the pending ADDI
    req(3'd6, 5'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
    tick();
    idle();
    check("rli_lui", out_inst, 32'h123462B7);
    out_ready = 1'b0;
    rst_n     = 1'b0;
    tick();
    check("rli_rst_valid", {31'd0, out_valid}, 32'd0);
    check("rli_rst_addr", {30'd0, out_addr}, 32'd0);
    check("rli_rst_inst", out_inst, 32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    check("rli_post_valid", {31'd0, out_valid}, 32'd0);
    check("rli_post_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("rli_post2_valid", {31'd0, out_valid}, 32'd0);
    check("rli_post2_addr", {30'd0, out_addr}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
